// File: rtl/game_judge_pkg.sv
// game_judge_pkg
//   Shared definitions for the rhythm-game timing judge.
//   - JUDGE_* : 2-bit judge codes, also decoded by the 7-segment judge display
//   - state_t : note FSM states (waiting for a note / note active awaiting press)
package game_judge_pkg;

    localparam logic [1:0] JUDGE_IDLE    = 2'b00;
    localparam logic [1:0] JUDGE_MISS    = 2'b01;
    localparam logic [1:0] JUDGE_NORMAL  = 2'b10;
    localparam logic [1:0] JUDGE_PERFECT = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LATE = 1'b1
    } state_t;

endpackage

// File: rtl/u_game_btn_sync.sv
// u_game_btn_sync
//   Brings the raw player button into the clk domain and turns each rising
//   edge into a single-cycle event.
//   Ports:
//     clk          system clock
//     rst          asynchronous active-low reset
//     i_btn        raw button, active-high, asynchronous to clk
//     o_press_evt  one-cycle pulse per button press (held button = one pulse)
module u_game_btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press_evt
);

    logic sync1;
    logic sync2;
    logic sync_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            sync1  <= i_btn;
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    assign o_press_evt = sync2 & ~sync_d;

endmodule

// File: rtl/u_game_judge.sv
// u_game_judge
//   Grades a player's button press against a note's ideal hit instant as
//   PERFECT / NORMAL / MISS, holds the grade for the judge display, and keeps
//   a running combo count.
//   Ports:
//     clk          system clock
//     rst          asynchronous active-low reset
//     i_note       one-cycle pulse at a note's ideal hit instant
//     i_btn        raw player button, active-high, asynchronous
//     o_judge      judge code: 00 IDLE, 01 MISS, 10 NORMAL, 11 PERFECT
//     o_judge_stb  one-cycle pulse on every new judgement
//     o_combo      consecutive PERFECT/NORMAL count, saturating at 255
module u_game_judge
    import game_judge_pkg::*;
#(
    parameter int PERFECT_WIN = 2_500_000,
    parameter int NORMAL_WIN  = 7_500_000,
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int CNT_W       = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_note,
    input  logic       i_btn,
    output logic [1:0] o_judge,
    output logic       o_judge_stb,
    output logic [7:0] o_combo
);

    localparam logic [CNT_W-1:0] P_LIM   = CNT_W'(PERFECT_WIN);
    localparam logic [CNT_W-1:0] N_LIM   = CNT_W'(NORMAL_WIN);
    localparam logic [CNT_W-1:0] AGE_MAX = CNT_W'(NORMAL_WIN + 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state;
    state_t           state_nx;
    logic             press_evt;
    logic             press_pending;
    logic [CNT_W-1:0] press_age;
    logic [CNT_W-1:0] late_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic             pend_ok;
    logic             judge_vld;
    logic [1:0]       judge_code;
    logic             late_clr;

    u_game_btn_sync u_btn_sync (
        .clk         (clk),
        .rst         (rst),
        .i_btn       (i_btn),
        .o_press_evt (press_evt)
    );

    // A pending press whose age has run past the NORMAL window is stale for
    // the one cycle before press_pending drops.
    assign pend_ok = press_pending && (press_age <= N_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        judge_vld  = 1'b0;
        judge_code = JUDGE_IDLE;
        late_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_note) begin
                    if (press_evt) begin
                        judge_vld  = 1'b1;
                        judge_code = JUDGE_PERFECT;
                    end else if (pend_ok) begin
                        judge_vld  = 1'b1;
                        judge_code = (press_age <= P_LIM) ? JUDGE_PERFECT : JUDGE_NORMAL;
                    end else begin
                        state_nx = ST_LATE;
                        late_clr = 1'b1;
                    end
                end
            end
            ST_LATE: begin
                if (press_evt) begin
                    judge_vld  = 1'b1;
                    judge_code = (late_cnt <= P_LIM) ? JUDGE_PERFECT : JUDGE_NORMAL;
                    state_nx   = ST_IDLE;
                end else if (i_note || (late_cnt == N_LIM)) begin
                    judge_vld  = 1'b1;
                    judge_code = JUDGE_MISS;
                    state_nx   = ST_IDLE;
                end
                // A new note always (re)starts the late window, whatever
                // happened to the old one this cycle.
                if (i_note) begin
                    state_nx = ST_LATE;
                    late_clr = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Early-press tracking and late-window counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            press_pending <= 1'b0;
            press_age     <= '0;
            late_cnt      <= '0;
        end else begin
            if ((state == ST_IDLE) && i_note) begin
                press_pending <= 1'b0;
            end else if ((state == ST_IDLE) && press_evt) begin
                press_pending <= 1'b1;
                press_age     <= '0;
            end else if (press_pending) begin
                if (press_age > N_LIM) begin
                    press_pending <= 1'b0;
                end
                if (press_age != AGE_MAX) begin
                    press_age <= press_age + ONE;
                end
            end

            if (late_clr || (state_nx == ST_IDLE)) begin
                late_cnt <= '0;
            end else begin
                late_cnt <= late_cnt + ONE;
            end
        end
    end

    // Judge display hold, strobe and combo.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_judge     <= JUDGE_IDLE;
            o_judge_stb <= 1'b0;
            o_combo     <= '0;
            hold_cnt    <= '0;
        end else begin
            if (judge_vld) begin
                o_judge     <= judge_code;
                o_judge_stb <= 1'b1;
                hold_cnt    <= HOLD_LD;
                if (judge_code == JUDGE_MISS) begin
                    o_combo <= '0;
                end else if (o_combo != 8'hFF) begin
                    o_combo <= o_combo + 8'd1;
                end
            end else begin
                o_judge_stb <= 1'b0;
                if (o_judge != JUDGE_IDLE) begin
                    if (hold_cnt == '0) begin
                        o_judge <= JUDGE_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_u_game_judge.sv
// tb_u_game_judge
//   Self-checking bench for u_game_judge with small windows
//   (PERFECT_WIN=4, NORMAL_WIN=10, HOLD_CYCLES=20). A timestamp-based
//   reference model predicts judge/strobe/combo every cycle; table rows and
//   hand sequences add fixed expectations for the window boundaries.
module tb_u_game_judge;
    import game_judge_pkg::*;

    localparam int PW   = 4;
    localparam int NW   = 10;
    localparam int HOLD = 20;
    localparam int NONE = 99;
    localparam int HMAX = 8192;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_note = 1'b0;
    logic       i_btn = 1'b0;
    logic [1:0] o_judge;
    logic       o_judge_stb;
    logic [7:0] o_combo;

    int n_tests = 0;
    int n_fail  = 0;

    u_game_judge #(
        .PERFECT_WIN (PW),
        .NORMAL_WIN  (NW),
        .HOLD_CYCLES (HOLD),
        .CNT_W       (25)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_note      (i_note),
        .i_btn       (i_btn),
        .o_judge     (o_judge),
        .o_judge_stb (o_judge_stb),
        .o_combo     (o_combo)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // ---------------- reference model (absolute cycle timestamps) ----------
    bit         hist [HMAX];
    int         T = 0;          // index of the cycle being evaluated
    int         since = 0;      // first cycle after the last reset release
    bit         late_act;
    int         note_t;
    bit         pend;
    int         press_t;
    logic [1:0] m_code;
    int         m_jt;
    int         m_combo;
    logic [1:0] exp_judge;
    bit         exp_stb;

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    function automatic bit bh(input int x);
        return (x >= since) ? hist[x] : 1'b0;
    endfunction

    function automatic logic [1:0] grade(input int d);
        return (d <= PW) ? JUDGE_PERFECT : JUDGE_NORMAL;
    endfunction

    task automatic model_reset();
        late_act  = 1'b0;
        pend      = 1'b0;
        m_code    = JUDGE_IDLE;
        m_jt      = -100000;
        m_combo   = 0;
        since     = T;
        exp_judge = JUDGE_IDLE;
        exp_stb   = 1'b0;
    endtask

    // Evaluate one cycle with its inputs; result is what the edge ending it registers.
    task automatic model_step(input bit note, input bit btn);
        bit         pe;
        logic [1:0] res;
        int         d;
        if (T >= HMAX) begin
            $display("FAIL model_capacity: got cycle %0d, expected < %0d", T, HMAX);
            $fatal(1);
        end
        hist[T] = btn;
        // button sampled high two cycles ago, low three cycles ago
        pe  = bh(T - 2) && !bh(T - 3);
        res = JUDGE_IDLE;
        if (late_act) begin
            d = T - note_t - 1;
            if (pe) begin
                res      = grade(d);
                late_act = 1'b0;
            end else if (note || d == NW) begin
                res      = JUDGE_MISS;
                late_act = 1'b0;
            end
            if (note) begin
                late_act = 1'b1;
                note_t   = T;
            end
        end else if (note) begin
            if (pe) res = JUDGE_PERFECT;
            else if (pend && (T - press_t - 1) <= NW) res = grade(T - press_t - 1);
            else begin
                late_act = 1'b1;
                note_t   = T;
            end
            pend = 1'b0;
        end else if (pe) begin
            pend    = 1'b1;
            press_t = T;
        end
        exp_stb = (res != JUDGE_IDLE);
        if (exp_stb) begin
            m_code = res;
            m_jt   = T;
            if (res == JUDGE_MISS) m_combo = 0;
            else if (m_combo < 255) m_combo++;
        end
        exp_judge = (T - m_jt < HOLD) ? m_code : JUDGE_IDLE;
        T++;
    endtask

    // Called at a negedge; drives one cycle and checks outputs at the next negedge.
    task automatic drive(input bit note, input bit btn);
        i_note = note;
        i_btn  = btn;
        @(posedge clk);
        model_step(note, btn);
        @(negedge clk);
        chk("judge", o_judge, exp_judge);
        chk("stb", o_judge_stb, exp_stb);
        chk("combo", o_combo, m_combo);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_judge", o_judge, JUDGE_IDLE);
        chk("rst_stb", o_judge_stb, 0);
        chk("rst_combo", o_combo, 0);
        model_reset();
        i_note = 1'b0;
        i_btn  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- table of single-note scenarios -----------------------
    // rel = press_evt cycle minus note cycle (NONE = no press);
    // at  = window index of the first strobe (note is at index 25).
    typedef struct {
        int         rel;
        logic [1:0] code;
        int         at;
    } vec_t;

    vec_t vt [13];

    initial begin
        int         nstb;
        int         gat;
        logic [1:0] gcode;
        int         cnt;
        int         s_at [4];
        logic [1:0] s_code [4];
        bit         lvl;

        vt[0]  = '{0,    JUDGE_PERFECT, 25};
        vt[1]  = '{-3,   JUDGE_PERFECT, 25};
        vt[2]  = '{-5,   JUDGE_PERFECT, 25};
        vt[3]  = '{-6,   JUDGE_NORMAL,  25};
        vt[4]  = '{-11,  JUDGE_NORMAL,  25};
        vt[5]  = '{-12,  JUDGE_MISS,    36};
        vt[6]  = '{1,    JUDGE_PERFECT, 26};
        vt[7]  = '{5,    JUDGE_PERFECT, 30};
        vt[8]  = '{6,    JUDGE_NORMAL,  31};
        vt[9]  = '{8,    JUDGE_NORMAL,  33};
        vt[10] = '{11,   JUDGE_NORMAL,  36};
        vt[11] = '{12,   JUDGE_MISS,    36};
        vt[12] = '{NONE, JUDGE_MISS,    36};

        // power-on reset
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("por_judge", o_judge, JUDGE_IDLE);
        chk("por_stb", o_judge_stb, 0);
        chk("por_combo", o_combo, 0);
        rst = 1'b1;

        for (int r = 0; r < 13; r++) begin
            nstb  = 0;
            gat   = -1;
            gcode = JUDGE_IDLE;
            for (int i = 0; i < 60; i++) begin
                drive(i == 25, (vt[r].rel != NONE) && (i >= 25 + vt[r].rel - 2) && (i <= 25 + vt[r].rel));
                if (o_judge_stb) begin
                    nstb++;
                    if (nstb == 1) begin
                        gcode = o_judge;
                        gat   = i;
                    end
                end
            end
            chk($sformatf("row%0d_code", r), gcode, vt[r].code);
            chk($sformatf("row%0d_at", r), gat, vt[r].at);
            chk($sformatf("row%0d_nstb", r), nstb, 1);
        end

        // NORMAL then PERFECT six cycles apart: display switches and hold restarts
        cnt = 0;
        for (int i = 0; i < 51; i++) begin
            drive((i == 2) || (i == 16), ((i >= 8) && (i < 10)) || (i == 14));
            if (i == 10) chk("hold_first", o_judge, JUDGE_NORMAL);
            if (i == 16) chk("hold_second", o_judge, JUDGE_PERFECT);
            if (o_judge == JUDGE_PERFECT) cnt++;
        end
        chk("hold_len", cnt, HOLD);

        // second note while late: MISS for the first, then press grades the second
        nstb = 0;
        for (int i = 0; i < 41; i++) begin
            drive((i == 2) || (i == 7), i == 8);
            if (o_judge_stb && nstb < 4) begin
                s_code[nstb] = o_judge;
                s_at[nstb]   = i;
                nstb++;
            end
        end
        chk("relate_nstb", nstb, 2);
        chk("relate_code0", s_code[0], JUDGE_MISS);
        chk("relate_at0", s_at[0], 7);
        chk("relate_code1", s_code[1], JUDGE_PERFECT);
        chk("relate_at1", s_at[1], 10);
        chk("relate_combo", o_combo, 1);

        // combo saturation, from a clean reset
        do_reset();
        for (int h = 1; h <= 300; h++) begin
            drive(1'b0, 1'b1);
            drive(1'b0, 1'b0);
            drive(1'b1, 1'b0);
            chk("combo_sat", o_combo, (h < 255) ? h : 255);
            drive(1'b0, 1'b0);
        end
        // reset in the middle of a hold
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0);

        // reset in the middle of a late window: no MISS afterwards
        drive(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0);
        do_reset();
        nstb = 0;
        for (int i = 0; i < 30; i++) begin
            drive(1'b0, 1'b0);
            if (o_judge_stb) nstb++;
        end
        chk("abort_nstb", nstb, 0);

        // randomized notes and button activity
        lvl = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) lvl = ~lvl;
            drive($urandom_range(0, 11) == 0, lvl);
        end
        for (int i = 0; i < 30; i++) drive(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/u_game_judge.md
Name: u_game_judge

Overview:
- Timing-judge stage of the rhythm game. It compares the player's button press against the note's ideal hit instant and grades the hit as PERFECT, NORMAL or MISS.
- It drives the 2-bit judge code consumed directly by the 8-digit 7-segment judge display (00 IDLE, 01 MISS, 10 NORMAL, 11 PERFECT).
- It holds each result for a fixed display time, then returns to IDLE.
- It also keeps a running combo count.

Parameters:
- PERFECT_WIN, 2_500_000: max |press − note| in cycles that grades PERFECT.
- NORMAL_WIN, 7_500_000: max |press − note| in cycles that grades NORMAL. Must be > PERFECT_WIN.
- HOLD_CYCLES, 25_000_000: cycles a non-IDLE judge stays on o_judge.
- CNT_W, 25: width of the internal timing counters. Must hold max(NORMAL_WIN+1, HOLD_CYCLES).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- i_note  in  1  one-cycle pulse at a note's ideal hit instant (from note scheduler).
- i_btn  in  1  raw player button, active-high, asynchronous to clk.
- o_judge  out  2  judge code to the 7-segment block: 00 IDLE, 01 MISS, 10 NORMAL, 11 PERFECT.
- o_judge_stb  out  1  one-cycle pulse on every new judgement.
- o_combo  out  8  consecutive PERFECT/NORMAL count.

Behaviour:
- Reset (rst=0, async): o_judge=00, o_judge_stb=0, o_combo=0. All counters 0, FSM in IDLE, no pending press, synchronizer flops 0.
- Button input:
  - i_btn passes through a 2-flop synchronizer, then a rising-edge detector giving a 1-cycle press_evt.
  - If i_btn is sampled high at edge k, press_evt is high during cycle k+1..k+2.
  - A judgement caused by that press is registered at edge k+2.
  - Holding the button produces no further events.
- Early press:
  - press_evt while no note is active sets press_pending and clears press_age to 0.
  - press_age increments each cycle and saturates at NORMAL_WIN+1.
  - press_pending clears when press_age exceeds NORMAL_WIN; the press is then ignored, with no judge output.
  - A new press_evt while pending restarts press_age at 0.
- Note FSM:
  - IDLE:
    - On i_note with press_pending: press_age≤PERFECT_WIN → PERFECT; else press_age≤NORMAL_WIN → NORMAL. The press is consumed and the FSM stays IDLE.
    - On i_note with no pending press: go to LATE with late_cnt=0.
  - LATE: late_cnt increments each cycle.
    - press_evt with late_cnt≤PERFECT_WIN → PERFECT, go to IDLE.
    - press_evt with late_cnt≤NORMAL_WIN → NORMAL, go to IDLE.
    - late_cnt reaching NORMAL_WIN+1 with no press → MISS, go to IDLE.
- Simultaneous events:
  - i_note and press_evt in the same cycle in IDLE → age 0 → PERFECT.
  - New i_note while in LATE → old note judged MISS that cycle; the FSM stays in LATE with late_cnt=0 for the new note.
  - i_note and press_evt together while in LATE → the press grades the old note, and the new note enters LATE.
- Output hold:
  - Each judgement loads o_judge with the code, pulses o_judge_stb for 1 cycle, and loads hold_cnt=HOLD_CYCLES−1.
  - hold_cnt decrements each cycle; o_judge returns to 00 the cycle after hold_cnt reaches 0.
  - A new judgement during a hold overwrites the code and restarts the hold.
- Combo:
  - PERFECT/NORMAL increments o_combo, saturating at 255.
  - MISS clears o_combo to 0.
  - o_combo updates on the same edge as o_judge_stb.
- Reset mid-operation: rst asserted during LATE or during a hold immediately returns all state and outputs to reset values. No MISS is generated for the aborted note.

Decomposition:
- Package game_judge_pkg:
  - judge code constants JUDGE_IDLE/MISS/NORMAL/PERFECT, shared with the 7-segment judge display;
  - FSM state encoding ST_IDLE, ST_LATE.
- Sub-module u_game_btn_sync: 2-flop synchronizer plus rising-edge detector producing press_evt.

Test Plan (PERFECT_WIN=4, NORMAL_WIN=10, HOLD_CYCLES=20):
- Late PERFECT: i_btn rises at edge k=i_note+1 → at edge k+2, o_judge=11, o_judge_stb=1 for 1 cycle, o_combo=1; o_judge=00 after 20 cycles.
- Late NORMAL: press_evt 8 cycles after i_note → o_judge=10, o_combo increments. Late MISS: no press → o_judge=01 exactly 11 cycles after i_note, o_combo=0.
- Early grading: press_evt 3 cycles before i_note → PERFECT on the i_note edge. Press 12 cycles before i_note → press ignored; the note enters LATE, then MISS.
- Simultaneous: i_note with press_evt in the same cycle → PERFECT. Second i_note 5 cycles into LATE → MISS strobe, then a press 2 cycles later → PERFECT.
- Hold/combo: NORMAL then PERFECT 6 cycles apart → o_judge 10→11, hold restarts to 20 cycles. 300 consecutive hits → o_combo saturates at 255.
- Reset: rst=0 mid-LATE and mid-hold → o_judge=00, o_combo=0, o_judge_stb=0 asynchronously; no MISS after release.
